pattern_shift_engine: RTL and testbench

//  Parametrised LED pattern engine: a W-bit shift register advanced by an

---
 rtl/pattern_shift_engine.sv | 132 +++++++++++++
 tb/tb_pattern_shift_engine.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_shift_engine.sv
`default_nettype none
// ============================================================================
// Module      : pattern_shift_engine
// Description : LED pattern engine. A W-bit register advanced by an internal
//               prescaler tick or a manual step pulse, in serial shift,
//               rotate or bounce ("ping-pong") mode, with parallel load and
//               pause.
// Ports       : clk        - system clock
//               rst        - synchronous active-high reset
//               mode       - 0 SHIFT, 1 ROTATE, 2 BOUNCE, 3 HOLD
//               dir        - 0 right (towards bit 0), 1 left (SHIFT/ROTATE);
//                            also the bounce direction taken on load
//               serial_in  - fill bit for SHIFT mode
//               load       - parallel load strobe (beats any advance)
//               load_data  - value loaded into q
//               pause      - freezes the prescaler and masks tick
//               step       - one-cycle manual advance pulse
//               q          - register contents (registered)
//               tick       - prescaler pulse, one cycle per 2**TICK_DIV
//               bounce_dir - bounce state: 0 MOVE_R, 1 MOVE_L (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_shift_engine #(
    parameter int             W             = 8,
    parameter int             TICK_DIV      = 23,
    parameter logic [W-1:0]   RESET_PATTERN = {{(W-1){1'b0}}, 1'b1}
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    mode,
    input  logic          dir,
    input  logic          serial_in,
    input  logic          load,
    input  logic [W-1:0]  load_data,
    input  logic          pause,
    input  logic          step,
    output logic [W-1:0]  q,
    output logic          tick,
    output logic          bounce_dir
);

    localparam logic [1:0]          c_MODE_SHIFT  = 2'd0;
    localparam logic [1:0]          c_MODE_ROTATE = 2'd1;
    localparam logic [1:0]          c_MODE_BOUNCE = 2'd2;

    localparam logic [0:0]          c_MOVE_R      = 1'b0;
    localparam logic [0:0]          c_MOVE_L      = 1'b1;

    localparam logic [TICK_DIV-1:0] c_CNT_ONE     = {{(TICK_DIV-1){1'b0}}, 1'b1};

    logic [TICK_DIV-1:0] r_cnt;
    logic [W-1:0]        r_q;
    logic [0:0]          r_bounce_dir;

    logic                w_tick;
    logic                w_advance;
    logic [W-1:0]        w_q_next;
    logic [0:0]          w_bounce_dir_next;

    // Tick is decoded straight from the count so an advance lands in the
    // same cycle the tick is visible; pause masks it because the count is
    // frozen and would otherwise fire on every paused cycle at all-ones.
    assign w_tick    = (r_cnt == {TICK_DIV{1'b1}}) && !pause;
    assign w_advance = w_tick | step;

    // Next-state / next-pattern logic. Load wins over advance, so a tick or
    // step coinciding with a load is simply lost.
    always_comb begin
        w_q_next          = r_q;
        w_bounce_dir_next = r_bounce_dir;
        if (load) begin
            w_q_next          = load_data;
            w_bounce_dir_next = dir;
        end else if (w_advance) begin
            case (mode)
                c_MODE_SHIFT: begin
                    if (dir) w_q_next = {r_q[W-2:0], serial_in};
                    else     w_q_next = {serial_in, r_q[W-1:1]};
                end
                c_MODE_ROTATE: begin
                    if (dir) w_q_next = {r_q[W-2:0], r_q[W-1]};
                    else     w_q_next = {r_q[0], r_q[W-1:1]};
                end
                c_MODE_BOUNCE: begin
                    // Reaching the end bit reverses and moves away in the same
                    // advance; an all-zero pattern never hits an end, so it
                    // stays zero with the direction untouched.
                    if (r_bounce_dir == c_MOVE_R) begin
                        if (r_q[0]) begin
                            w_bounce_dir_next = c_MOVE_L;
                            w_q_next          = {r_q[W-2:0], 1'b0};
                        end else begin
                            w_q_next          = {1'b0, r_q[W-1:1]};
                        end
                    end else begin
                        if (r_q[W-1]) begin
                            w_bounce_dir_next = c_MOVE_R;
                            w_q_next          = {1'b0, r_q[W-1:1]};
                        end else begin
                            w_q_next          = {r_q[W-2:0], 1'b0};
                        end
                    end
                end
                default: begin
                    w_q_next          = r_q;
                    w_bounce_dir_next = r_bounce_dir;
                end
            endcase
        end
    end

    // State registers. Load leaves the prescaler running undisturbed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_q          <= RESET_PATTERN;
            r_bounce_dir <= c_MOVE_R;
        end else begin
            r_q          <= w_q_next;
            r_bounce_dir <= w_bounce_dir_next;
            if (!pause) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
        end
    end

    assign q          = r_q;
    assign tick       = w_tick;
    assign bounce_dir = r_bounce_dir[0];

endmodule
`default_nettype wire

// File: tb/tb_pattern_shift_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_pattern_shift_engine
// Description : Self-checking bench for pattern_shift_engine (W=8,
//               TICK_DIV=2). Directed scenarios followed by random stimulus,
//               all compared every cycle against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pattern_shift_engine;

    localparam int W        = 8;
    localparam int TICK_DIV = 2;
    localparam int PERIOD   = 1 << TICK_DIV;

    logic         clk;
    logic         rst;
    logic [1:0]   mode;
    logic         dir;
    logic         serial_in;
    logic         load;
    logic [W-1:0] load_data;
    logic         pause;
    logic         step;
    logic [W-1:0] q;
    logic         tick;
    logic         bounce_dir;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int m_q;
    int m_bd;
    int m_cnt;
    int m_ticks = 0;

    pattern_shift_engine #(
        .W             (W),
        .TICK_DIV      (TICK_DIV),
        .RESET_PATTERN (8'h01)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .dir        (dir),
        .serial_in  (serial_in),
        .load       (load),
        .load_data  (load_data),
        .pause      (pause),
        .step       (step),
        .q          (q),
        .tick       (tick),
        .bounce_dir (bounce_dir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q   = 1;
        m_bd  = 0;
        m_cnt = 0;
    endtask

    // One clock cycle: inputs are already set (clock low). Checks tick before
    // the edge, then q and bounce_dir after it, and returns on the next negedge.
    task automatic step_cycle();
        int exp_tick;
        int adv;
        int nq;
        int nbd;
        #1;
        exp_tick = (m_cnt == PERIOD - 1 && !pause) ? 1 : 0;
        check("tick", {31'd0, tick}, exp_tick);
        if (exp_tick == 1) m_ticks++;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            adv = (exp_tick == 1 || step) ? 1 : 0;
            nq  = m_q;
            nbd = m_bd;
            if (load) begin
                nq  = load_data;
                nbd = dir;
            end else if (adv == 1) begin
                case (mode)
                    2'd0: nq = dir ? (m_q * 2) % 256 + serial_in : m_q / 2 + serial_in * 128;
                    2'd1: nq = dir ? (m_q * 2) % 256 + m_q / 128 : m_q / 2 + (m_q % 2) * 128;
                    2'd2: begin
                        if (m_q != 0) begin
                            if (m_bd == 0) begin
                                if (m_q % 2 == 1) begin nbd = 1; nq = (m_q * 2) % 256; end
                                else nq = m_q / 2;
                            end else begin
                                if (m_q >= 128) begin nbd = 0; nq = m_q / 2; end
                                else nq = (m_q * 2) % 256;
                            end
                        end
                    end
                    default: ;
                endcase
            end
            m_q  = nq;
            m_bd = nbd;
            if (!pause) m_cnt = (m_cnt + 1) % PERIOD;
        end
        #1;
        check("q", {24'd0, q}, m_q);
        check("bounce_dir", {31'd0, bounce_dir}, m_bd);
        @(negedge clk);
    endtask

    task automatic run_ticks(input int n);
        int target;
        int budget;
        target = m_ticks + n;
        budget = n * PERIOD + 8;
        while (m_ticks < target && budget > 0) begin
            step_cycle();
            budget--;
        end
        check("tick_budget", {31'd0, (m_ticks >= target)}, 1);
    endtask

    task automatic load_value(input logic [7:0] v, input logic d);
        load      = 1'b1;
        load_data = v;
        dir       = d;
        step_cycle();
        load      = 1'b0;
    endtask

    initial begin
        rst = 1'b1; mode = 2'd1; dir = 1'b0; serial_in = 1'b0;
        load = 1'b0; load_data = '0; pause = 1'b0; step = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check("rst_q", {24'd0, q}, 32'h01);
        check("rst_bd", {31'd0, bounce_dir}, 0);
        check("rst_tick", {31'd0, tick}, 0);
        @(negedge clk);
        rst = 1'b0;

        // 1: rotate right, 8 ticks bring the pattern home
        run_ticks(1);
        check("s1_q80", {24'd0, q}, 32'h80);
        run_ticks(1);
        check("s1_q40", {24'd0, q}, 32'h40);
        run_ticks(6);
        check("s1_wrap", {24'd0, q}, 32'h01);

        // 2: shift left filling ones, then zeros
        mode = 2'd0; serial_in = 1'b1;
        load_value(8'h00, 1'b1);
        run_ticks(3);
        check("s2_q07", {24'd0, q}, 32'h07);
        serial_in = 1'b0;
        run_ticks(8);
        check("s2_q00", {24'd0, q}, 32'h00);

        // 3: bounce
        mode = 2'd2;
        load_value(8'h01, 1'b0);
        run_ticks(1);
        check("s3_q02", {24'd0, q}, 32'h02);
        check("s3_bdL", {31'd0, bounce_dir}, 1);
        run_ticks(6);
        check("s3_q80", {24'd0, q}, 32'h80);
        run_ticks(1);
        check("s3_q40", {24'd0, q}, 32'h40);
        check("s3_bdR", {31'd0, bounce_dir}, 0);
        run_ticks(1);
        check("s3_q20", {24'd0, q}, 32'h20);
        load_value(8'h00, 1'b0);
        run_ticks(10);
        check("s3_zero", {24'd0, q}, 32'h00);

        // 4: pause with two manual steps
        mode = 2'd1;
        load_value(8'h01, 1'b0);
        pause = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step = (i == 5 || i == 9);
            step_cycle();
        end
        step = 1'b0; pause = 1'b0;
        check("s4_q40", {24'd0, q}, 32'h40);
        run_ticks(2);

        // 5: load coinciding with a tick
        for (int i = 0; i < PERIOD + 2 && m_cnt != PERIOD - 1; i++) step_cycle();
        load_value(8'hA5, 1'b1);
        check("s5_qA5", {24'd0, q}, 32'hA5);
        check("s5_bd", {31'd0, bounce_dir}, 1);

        // 6: reset beats load and step mid-bounce
        mode = 2'd2;
        load_value(8'h10, 1'b1);
        run_ticks(2);
        rst = 1'b1; load = 1'b1; load_data = 8'hFF; step = 1'b1;
        step_cycle();
        rst = 1'b0; load = 1'b0; step = 1'b0;
        check("s6_q", {24'd0, q}, 32'h01);
        check("s6_bd", {31'd0, bounce_dir}, 0);
        #1;
        check("s6_tick", {31'd0, tick}, 0);
        step_cycle();

        // Random stimulus
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom % 64) == 0;
            load      = ($urandom % 16) == 0;
            pause     = ($urandom % 4) == 0;
            step      = ($urandom % 8) == 0;
            mode      = 2'($urandom % 4);
            dir       = 1'($urandom % 2);
            serial_in = 1'($urandom % 2);
            load_data = 8'($urandom % 256);
            step_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
